seq_ctrl: RTL and testbench

Control sequencer for the single-bus CPU datapath. Runs the three-step instruction fetch (PC→MAR, memory→MDR, MDR→IR), decodes the IR opcode, and drives the register-transfer steps for register-register ALU, unary and (optionally) mul/div instructions. It replaces the hand-driven bus-enable and register-load strobes currently applied to the datapath.

---
 rtl/seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - control sequencer for the single-bus CPU datapath
// Optional mul/div sequence (T5m/T6, HI/LO loads) enabled by defining SEQ_CTRL_MULDIV_EN.
module seq_ctrl #(
  parameter int          NREG   = 16,
  parameter logic [31:0] PC_RST = 32'h0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     IR,
  input  logic            mem_ready,
  output logic            PC_out,
  output logic            Zlo_out,
  output logic            Zhi_out,
  output logic            MDR_out,
  output logic [NREG-1:0] R_wrt,
  output logic            MAR_rd,
  output logic            PC_rd,
  output logic            MDR_rd,
  output logic            IR_rd,
  output logic            Y_rd,
  output logic            Zlo_rd,
  output logic            HI_rd,
  output logic            LO_rd,
  output logic [NREG-1:0] R_rd,
  output logic            IncPC,
  output logic            Read,
  output logic [4:0]      op_sel,
  output logic [31:0]     pc_init,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_T3, S_T4, S_T4U, S_T5, S_T5M, S_T6, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01011;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_NEG    = 5'b10001;
  localparam logic [4:0] OP_NOT    = 5'b10010;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic [4:0] ir_op;
  logic       unused_ir;

  // IR is only trusted in DEC, the cycle after the datapath loads it in F2
  assign ir_op     = IR[31:27];
  assign unused_ir = ^IR[14:0];
  assign pc_init   = PC_RST;

  function automatic logic is_alu3(input logic [4:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
`ifdef SEQ_CTRL_MULDIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return 1'b0 & ^op;
`endif
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_alu3(op) || is_unary(op) || is_muldiv(op) || (op == OP_HALT);
  endfunction

  // Out-of-range register indices select nothing rather than aliasing
  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    if ({28'd0, idx} < NREG) v[idx] = 1'b1;
    return v;
  endfunction

  // State register and IR field latch; fields are captured on the DEC edge
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DEC) begin
        op_q <= IR[31:27];
        ra_q <= IR[26:23];
        rb_q <= IR[22:19];
        rc_q <= IR[18:15];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    if (mem_ready) state_d = S_F2;
      S_F2:    state_d = S_DEC;
      S_DEC: begin
        if (is_alu3(ir_op) || is_muldiv(ir_op)) state_d = S_T3;
        else if (is_unary(ir_op))               state_d = S_T4U;
        else if (ir_op == OP_HALT)              state_d = S_HALT;
        else                                    state_d = run ? S_F0 : S_IDLE;
      end
      S_T3:    state_d = S_T4;
      S_T4:    state_d = is_muldiv(op_q) ? S_T5M : S_T5;
      S_T4U:   state_d = S_T5;
      S_T5:    state_d = run ? S_F0 : S_IDLE;
      S_T5M:   state_d = S_T6;
      S_T6:    state_d = run ? S_F0 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state register and latched fields; one bus driver at most
  always_comb begin
    PC_out  = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    MDR_out = 1'b0;
    R_wrt   = '0;
    MAR_rd  = 1'b0;
    PC_rd   = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    HI_rd   = 1'b0;
    LO_rd   = 1'b0;
    R_rd    = '0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    op_sel  = '0;
    illegal = 1'b0;
    busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    halted  = (state_q == S_HALT);
    case (state_q)
      S_F0: begin
        PC_out = 1'b1;
        MAR_rd = 1'b1;
        IncPC  = 1'b1;
        Zlo_rd = 1'b1;
      end
      S_F1: begin
        Zlo_out = 1'b1;
        PC_rd   = 1'b1;
        Read    = 1'b1;
        MDR_rd  = 1'b1;
      end
      S_F2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
      end
      S_DEC: illegal = !is_legal(ir_op);
      S_T3: begin
        Y_rd  = 1'b1;
        R_wrt = is_muldiv(op_q) ? reg_sel(ra_q) : reg_sel(rb_q);
      end
      S_T4: begin
        R_wrt  = is_muldiv(op_q) ? reg_sel(rb_q) : reg_sel(rc_q);
        op_sel = op_q;
        Zlo_rd = 1'b1;
      end
      S_T4U: begin
        R_wrt  = reg_sel(rb_q);
        op_sel = op_q;
        Zlo_rd = 1'b1;
      end
      S_T5: begin
        Zlo_out = 1'b1;
        R_rd    = reg_sel(ra_q);
      end
`ifdef SEQ_CTRL_MULDIV_EN
      S_T5M: begin
        Zlo_out = 1'b1;
        LO_rd   = 1'b1;
      end
      S_T6: begin
        Zhi_out = 1'b1;
        HI_rd   = 1'b1;
        op_sel  = op_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - directed self-checking bench for seq_ctrl
module tb_seq_ctrl;

  logic        clk, clr, run, mem_ready;
  logic [31:0] IR;
  logic        PC_out, Zlo_out, Zhi_out, MDR_out;
  logic [15:0] R_wrt, R_rd;
  logic        MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd;
  logic        IncPC, Read, busy, halted, illegal;
  logic [4:0]  op_sel;
  logic [31:0] pc_init;
  logic [16:0] strb;

  int total = 0;
  int bad   = 0;

  localparam logic [16:0] S_PCO  = 17'h10000;
  localparam logic [16:0] S_ZLO  = 17'h08000;
  localparam logic [16:0] S_ZHO  = 17'h04000;
  localparam logic [16:0] S_MDRO = 17'h02000;
  localparam logic [16:0] S_MAR  = 17'h01000;
  localparam logic [16:0] S_PCR  = 17'h00800;
  localparam logic [16:0] S_MDRR = 17'h00400;
  localparam logic [16:0] S_IRR  = 17'h00200;
  localparam logic [16:0] S_YR   = 17'h00100;
  localparam logic [16:0] S_ZLR  = 17'h00080;
  localparam logic [16:0] S_HI   = 17'h00040;
  localparam logic [16:0] S_LO   = 17'h00020;
  localparam logic [16:0] S_INC  = 17'h00010;
  localparam logic [16:0] S_RD   = 17'h00008;
  localparam logic [16:0] S_BSY  = 17'h00004;
  localparam logic [16:0] S_HLT  = 17'h00002;
  localparam logic [16:0] S_ILL  = 17'h00001;

  localparam logic [16:0] E_IDLE = 17'h0;
  localparam logic [16:0] E_F0   = S_PCO | S_MAR | S_INC | S_ZLR | S_BSY;
  localparam logic [16:0] E_F1   = S_ZLO | S_PCR | S_RD | S_MDRR | S_BSY;
  localparam logic [16:0] E_F2   = S_MDRO | S_IRR | S_BSY;
  localparam logic [16:0] E_DEC  = S_BSY;
  localparam logic [16:0] E_T3   = S_YR | S_BSY;
  localparam logic [16:0] E_T4   = S_ZLR | S_BSY;
  localparam logic [16:0] E_T5   = S_ZLO | S_BSY;

  assign strb = {PC_out, Zlo_out, Zhi_out, MDR_out, MAR_rd, PC_rd, MDR_rd, IR_rd,
                 Y_rd, Zlo_rd, HI_rd, LO_rd, IncPC, Read, busy, halted, illegal};

  seq_ctrl #(.NREG(16), .PC_RST(32'h0)) dut (
    .clk(clk), .clr(clr), .run(run), .IR(IR), .mem_ready(mem_ready),
    .PC_out(PC_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .MDR_out(MDR_out),
    .R_wrt(R_wrt), .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
    .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .HI_rd(HI_rd), .LO_rd(LO_rd), .R_rd(R_rd),
    .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .pc_init(pc_init),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [16:0] s, input logic [15:0] wrt,
                           input logic [15:0] rd, input logic [4:0] op);
    chk({tag, ".strb"}, {15'd0, strb}, {15'd0, s});
    chk({tag, ".wrt"},  {16'd0, R_wrt}, {16'd0, wrt});
    chk({tag, ".rd"},   {16'd0, R_rd},  {16'd0, rd});
    chk({tag, ".op"},   {27'd0, op_sel}, {27'd0, op});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starting in F0 with mem_ready high, walk F0/F1/F2 and stop in DEC
  task automatic run_fetch(input string tag);
    chk_state({tag, ".f0"}, E_F0, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state({tag, ".f1"}, E_F1, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state({tag, ".f2"}, E_F2, 16'h0, 16'h0, 5'd0);
    tick;
  endtask

  initial begin
    clr = 1'b1; run = 1'b1; mem_ready = 1'b1; IR = 32'h0;

    // reset held two cycles overrides run
    tick;
    chk_state("rst0", E_IDLE, 16'h0, 16'h0, 5'd0);
    chk("pc_init", pc_init, 32'h0);
    tick;
    chk_state("rst1", E_IDLE, 16'h0, 16'h0, 5'd0);
    clr = 1'b0;
    IR  = 32'h2A238000;   // and: Ra=4 Rb=4 Rc=7
    tick;

    // three-register ALU op, back-to-back into next fetch
    run_fetch("and");
    chk_state("and.dec", E_DEC, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state("and.t3", E_T3, 16'h0010, 16'h0, 5'd0);
    tick;
    chk_state("and.t4", E_T4, 16'h0080, 16'h0, 5'b00101);
    tick;
    chk_state("and.t5", E_T5, 16'h0, 16'h0010, 5'd0);
    IR        = 32'h89180000;   // neg: Ra=2 Rb=3
    mem_ready = 1'b0;
    tick;

    // unary op with three wait cycles in F1
    chk_state("neg.f0", E_F0, 16'h0, 16'h0, 5'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      chk_state($sformatf("neg.f1w%0d", i), E_F1, 16'h0, 16'h0, 5'd0);
      tick;
    end
    chk_state("neg.f2", E_F2, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state("neg.dec", E_DEC, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state("neg.t4u", E_T4, 16'h0008, 16'h0, 5'b10001);
    run = 1'b0;
    tick;
    chk_state("neg.t5", E_T5, 16'h0, 16'h0004, 5'd0);
    tick;
    chk_state("neg.idle0", E_IDLE, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state("neg.idle1", E_IDLE, 16'h0, 16'h0, 5'd0);

    // undecoded opcode 11111: single-cycle illegal pulse, then F0
    IR  = 32'hFFFF8000;
    run = 1'b1;
    tick;
    run_fetch("ill");
    chk_state("ill.dec", E_DEC | S_ILL, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state("ill.next", E_F0, 16'h0, 16'h0, 5'd0);

`ifndef SEQ_CTRL_MULDIV_EN
    // div opcode is undecoded without the mul/div option
    IR = 32'h80000000;
    run_fetch("div");
    chk_state("div.dec", E_DEC | S_ILL, 16'h0, 16'h0, 5'd0);
    tick;
`endif

    // halt parks until clr regardless of run
    IR = 32'hD8000000;
    run_fetch("halt");
    chk_state("halt.dec", E_DEC, 16'h0, 16'h0, 5'd0);
    tick;
    for (int i = 0; i < 20; i++) begin
      chk_state($sformatf("halt.h%0d", i), S_HLT, 16'h0, 16'h0, 5'd0);
      tick;
    end
    clr = 1'b1;
    tick;
    chk_state("halt.clr", E_IDLE, 16'h0, 16'h0, 5'd0);
    clr = 1'b0;
    IR  = 32'h2A238000;
    tick;

    // clr in T4 aborts with no register load afterwards
    run_fetch("abrt");
    chk_state("abrt.dec", E_DEC, 16'h0, 16'h0, 5'd0);
    tick;
    chk_state("abrt.t3", E_T3, 16'h0010, 16'h0, 5'd0);
    tick;
    chk_state("abrt.t4", E_T4, 16'h0080, 16'h0, 5'b00101);
    clr = 1'b1;
    tick;
    chk_state("abrt.clr", E_IDLE, 16'h0, 16'h0, 5'd0);
    clr = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_state($sformatf("abrt.post%0d", i), E_IDLE, 16'h0, 16'h0, 5'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
